// File: rtl/seq_cascade_ctrl_pkg.sv
// Shared types and helpers for the cascaded sequence controller.
// Phase encoding, direction encoding and the phase-step function.
package seq_cascade_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic phase_t next_phase(input phase_t p, input logic dir);
    phase_t n;
    n = p;
    case (p)
      P0: n = (dir == DIR_UP) ? P1 : P3;
      P1: n = (dir == DIR_UP) ? P2 : P0;
      P2: n = (dir == DIR_UP) ? P3 : P1;
      P3: n = (dir == DIR_UP) ? P0 : P2;
      default: n = P0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_cascade_ctrl_if.sv
// Control/status bundle between the sequencer and its driver.
// SEQ_CASCADE_HOLD_EN adds the hold input.
interface seq_cascade_ctrl_if #(
  parameter int STAGE_W = 4,
  parameter int NUM_CH  = 4
);
  import seq_cascade_pkg::*;

  logic               clear;
  logic               tog_run;
  logic               tog_dir;
`ifdef SEQ_CASCADE_HOLD_EN
  logic               hold;
`endif
  logic               tick;
  logic               wrap;
  logic [STAGE_W-1:0] stage;
  phase_t             phase;
  logic [NUM_CH-1:0]  ch_out;
  logic               running;

  modport master (
`ifdef SEQ_CASCADE_HOLD_EN
    output hold,
`endif
    output clear, tog_run, tog_dir,
    input  tick, wrap, stage, phase, ch_out, running
  );

  modport slave (
`ifdef SEQ_CASCADE_HOLD_EN
    input  hold,
`endif
    input  clear, tog_run, tog_dir,
    output tick, wrap, stage, phase, ch_out, running
  );

endinterface

// File: rtl/seq_cascade_ctrl_mod_counter.sv
// Modulo-MOD up/down counter with synchronous clear and a boundary flag.
// at_bound marks the value the next step would wrap from, for the current direction.
module mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic         down,
  output logic [W-1:0] cnt,
  output logic         at_bound
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Wrap by explicit compare so a non-power-of-two modulus never overflows naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (down) cnt_d = (cnt_q == '0) ? TOP : cnt_q - ONE;
      else      cnt_d = (cnt_q == TOP) ? '0  : cnt_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign at_bound = down ? (cnt_q == '0) : (cnt_q == TOP);

endmodule

// File: rtl/seq_cascade_ctrl.sv
// Cascaded sequencer: prescaler -> up/down stage counter -> 4-phase FSM and one-hot ring.
// Optional SEQ_CASCADE_HOLD_EN adds a hold input that freezes everything below the prescaler.
module seq_cascade_ctrl
  import seq_cascade_pkg::*;
#(
  parameter int PRESCALE_W   = 4,
  parameter int PRESCALE_MOD = 10,
  parameter int STAGE_W      = 4,
  parameter int MAX_STAGE    = 9,
  parameter int NUM_CH       = 4
) (
  input logic               clock,
  input logic               reset_n,
  seq_cascade_ctrl_if.slave bus
);

  localparam logic [NUM_CH-1:0] CH_INIT = NUM_CH'(1);

  logic              run_q, run_d;
  logic              dir_q, dir_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  phase_t            phase_q, phase_d;
  logic [NUM_CH-1:0] ch_q, ch_d;

  logic                  hold_i;
  logic                  pre_at_top;
  logic [PRESCALE_W-1:0] pre_cnt_unused;
  logic                  stage_at_bound;

`ifdef SEQ_CASCADE_HOLD_EN
  assign hold_i = bus.hold;
`else
  assign hold_i = 1'b0;
`endif

  mod_counter #(.W(PRESCALE_W), .MOD(PRESCALE_MOD)) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .en       (run_q),
    .down     (1'b0),
    .cnt      (pre_cnt_unused),
    .at_bound (pre_at_top)
  );

  mod_counter #(.W(STAGE_W), .MOD(MAX_STAGE + 1)) u_stage (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .en       (tick_q & ~hold_i),
    .down     (dir_q),
    .cnt      (bus.stage),
    .at_bound (stage_at_bound)
  );

  // Every stage consumes the pulse registered on the previous edge, using pre-edge run/dir.
  always_comb begin
    run_d   = run_q ^ bus.tog_run;
    dir_d   = dir_q ^ bus.tog_dir;
    tick_d  = run_q & pre_at_top;
    wrap_d  = tick_q & ~hold_i & stage_at_bound;
    phase_d = phase_q;
    ch_d    = ch_q;
    if (wrap_q && !hold_i) begin
      phase_d = next_phase(phase_q, dir_q);
      if (dir_q == DIR_UP) ch_d = {ch_q[NUM_CH-2:0], ch_q[NUM_CH-1]};
      else                 ch_d = {ch_q[0], ch_q[NUM_CH-1:1]};
    end
    if (bus.clear) begin
      run_d   = 1'b0;
      dir_d   = DIR_UP;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      phase_d = P0;
      ch_d    = CH_INIT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      phase_q <= P0;
      ch_q    <= CH_INIT;
    end else begin
      run_q   <= run_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      phase_q <= phase_d;
      ch_q    <= ch_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.phase   = phase_q;
  assign bus.ch_out  = ch_q;
  assign bus.running = run_q;

endmodule
